// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_pkg
//  Description : Shared FSM state encoding, default parameter constants and a
//                small helper for the GEMM tile engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

    localparam int c_DEF_P      = 4;
    localparam int c_DEF_DATA_W = 8;
    localparam int c_DEF_ACC_W  = 32;
    localparam int c_DEF_ADDR_W = 10;
    localparam int c_DEF_DIM_W  = 4;
    localparam int c_DEF_SAT    = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Number of P-wide tiles needed to cover a dimension
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_gemm_pe.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_gemm_pe
//  Description : One processing element: signed multiply, load-or-accumulate,
//                optional saturation and output lane masking.
//  Revision    : 1.0 - initial release
// ============================================================================
module tpu_gemm_pe
    import tpu_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int ACC_W  = c_DEF_ACC_W,
    parameter int SAT    = c_DEF_SAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_en_i,
    input  logic              first_i,
    input  logic              lane_ok_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]  acc_o
);

    localparam logic [ACC_W-1:0] c_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;
    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W:0]      w_prod_ext;
    logic [ACC_W:0]      w_sum;
    logic                w_ovf;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;

    // Operands sign-extended first so the low half of the product is the exact signed result
    assign w_a_ext    = {{DATA_W{a_i[DATA_W-1]}}, a_i};
    assign w_b_ext    = {{DATA_W{b_i[DATA_W-1]}}, b_i};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = {{(ACC_W+1-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign w_sum      = {acc_q[ACC_W-1], acc_q} + w_prod_ext;
    assign w_ovf      = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    // Next accumulator value: wrap by truncation, or clamp on signed overflow
    always_comb begin
        acc_d = w_sum[ACC_W-1:0];
        if ((SAT != 0) && w_ovf) begin
            acc_d = w_sum[ACC_W] ? c_MIN : c_MAX;
        end
    end

    // Accumulator: first product of a tile overwrites, later products add
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (acc_en_i) begin
            acc_q <= first_i ? w_prod_ext[ACC_W-1:0] : acc_d;
        end
    end

    assign acc_o = lane_ok_i ? acc_q : '0;

endmodule
`default_nettype wire

// File: rtl/tpu_gemm_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_gemm_engine
//  Description : Tiled GEMM engine. Streams k operand words per PxP tile from
//                the A/B buffers into a PxP PE array, then writes the tile
//                row by row into the output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tpu_gemm_engine
    import tpu_pkg::*;
#(
    parameter int P      = c_DEF_P,
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int ACC_W  = c_DEF_ACC_W,
    parameter int ADDR_W = c_DEF_ADDR_W,
    parameter int DIM_W  = c_DEF_DIM_W,
    parameter int SAT    = c_DEF_SAT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DIM_W-1:0]    m,
    input  logic [DIM_W-1:0]    n,
    input  logic [DIM_W-1:0]    k,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   index_a,
    output logic [ADDR_W-1:0]   index_b,
    input  logic [P*DATA_W-1:0] data_a,
    input  logic [P*DATA_W-1:0] data_b,
    output logic                wr_en_o,
    output logic [ADDR_W-1:0]   index_o,
    output logic [P*ACC_W-1:0]  data_o
);

    localparam int c_IW = (P > 1) ? $clog2(P) : 1;

    state_t              state_q;
    state_t              state_d;
    logic [DIM_W-1:0]    m_q;
    logic [DIM_W-1:0]    n_q;
    logic [DIM_W-1:0]    k_q;
    logic [DIM_W-1:0]    rb_q;
    logic [DIM_W-1:0]    cb_q;
    logic [DIM_W-1:0]    kk_q;
    logic [c_IW-1:0]     row_q;
    logic [ADDR_W-1:0]   a_base_q;
    logic [ADDR_W-1:0]   b_base_q;
    logic [ADDR_W-1:0]   o_base_q;
    logic                vld_q;
    logic                first_q;

    int                  w_rb;
    int                  w_nb;
    logic                w_zero_dim;
    logic                w_load_last;
    logic                w_write_last;
    logic                w_last_row;
    logic                w_last_col;
    logic                w_last_tile;
    logic [P-1:0]        w_row_ok;
    logic [P-1:0]        w_col_ok;
    logic [P-1:0][P-1:0][ACC_W-1:0] w_lane;

    assign w_rb         = ceil_div(int'(m_q), P);
    assign w_nb         = ceil_div(int'(n_q), P);
    assign w_zero_dim   = (m == '0) || (n == '0) || (k == '0);
    assign w_load_last  = (kk_q == (k_q - DIM_W'(1)));
    assign w_write_last = (row_q == c_IW'(P - 1));
    assign w_last_row   = (int'(rb_q) == (w_rb - 1));
    assign w_last_col   = (int'(cb_q) == (w_nb - 1));
    assign w_last_tile  = w_last_row && w_last_col;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a zero dimension skips straight to completion
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = w_zero_dim ? ST_DONE : ST_LOAD;
            ST_LOAD:  if (w_load_last) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_WRITE;
            ST_WRITE: if (w_write_last) state_d = w_last_tile ? ST_DONE : ST_LOAD;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; everything idles at zero outside its phase
    always_comb begin
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        wr_en_o = (state_q == ST_WRITE);
        index_a = '0;
        index_b = '0;
        index_o = '0;
        data_o  = '0;
        if (state_q == ST_LOAD) begin
            index_a = a_base_q + ADDR_W'(kk_q);
            index_b = b_base_q + ADDR_W'(kk_q);
        end
        if (state_q == ST_WRITE) begin
            index_o = o_base_q + ADDR_W'(row_q);
            data_o  = w_lane[row_q];
        end
    end

    // Tile walk counters, buffer base addresses and the one-cycle-late data-valid tags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            rb_q     <= '0;
            cb_q     <= '0;
            kk_q     <= '0;
            row_q    <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            o_base_q <= '0;
            vld_q    <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            vld_q   <= (state_q == ST_LOAD);
            first_q <= (state_q == ST_LOAD) && (kk_q == '0);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        m_q      <= m;
                        n_q      <= n;
                        k_q      <= k;
                        rb_q     <= '0;
                        cb_q     <= '0;
                        kk_q     <= '0;
                        row_q    <= '0;
                        a_base_q <= '0;
                        b_base_q <= '0;
                        o_base_q <= '0;
                    end
                end
                ST_LOAD: begin
                    kk_q <= w_load_last ? '0 : kk_q + DIM_W'(1);
                end
                ST_WRITE: begin
                    row_q <= w_write_last ? '0 : row_q + c_IW'(1);
                    if (w_write_last) begin
                        o_base_q <= o_base_q + ADDR_W'(P);
                        if (w_last_col) begin
                            cb_q     <= '0;
                            rb_q     <= rb_q + DIM_W'(1);
                            b_base_q <= '0;
                            a_base_q <= a_base_q + ADDR_W'(k_q);
                        end else begin
                            cb_q     <= cb_q + DIM_W'(1);
                            b_base_q <= b_base_q + ADDR_W'(k_q);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < P; gi++) begin : g_row
        assign w_row_ok[gi] = ((int'(rb_q) * P + gi) < int'(m_q));
        assign w_col_ok[gi] = ((int'(cb_q) * P + gi) < int'(n_q));
        for (genvar gj = 0; gj < P; gj++) begin : g_col
            tpu_gemm_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .SAT    (SAT)
            ) u_pe (
                .clk       (clk),
                .rst       (rst),
                .acc_en_i  (vld_q),
                .first_i   (first_q),
                .lane_ok_i (w_row_ok[gi] & w_col_ok[gj]),
                .a_i       (data_a[gi*DATA_W +: DATA_W]),
                .b_i       (data_b[gj*DATA_W +: DATA_W]),
                .acc_o     (w_lane[gi][gj])
            );
        end
    end

endmodule
`default_nettype wire
